// File: rtl/fnn_pkg.sv
// Shared fixed-point definitions for the feed-forward neuron layers.
package fnn_pkg;

  localparam int DATA_W    = 16;
  localparam int FRAC_BITS = 12;
  // Working width for the final narrowing; wide enough for any accumulator we build.
  localparam int WIDE_W    = 64;

  typedef logic signed [DATA_W-1:0] fxp_t;

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_DRAIN   = 2'd1,
    ST_EMIT    = 2'd2
  } mac_state_e;

  // Drop 'width' fractional bits (arithmetic shift, rounds toward -inf) and clamp to fxp_t range.
  function automatic fxp_t sat_narrow(input logic signed [WIDE_W-1:0] acc, input int unsigned width);
    logic signed [WIDE_W-1:0] res;
    logic signed [WIDE_W-1:0] max_v;
    logic signed [WIDE_W-1:0] min_v;
    res   = acc >>> width;
    max_v = (64'sd1 <<< (DATA_W - 1)) - 64'sd1;
    min_v = -(64'sd1 <<< (DATA_W - 1));
    if (res > max_v) begin
      return max_v[DATA_W-1:0];
    end else if (res < min_v) begin
      return min_v[DATA_W-1:0];
    end else begin
      return res[DATA_W-1:0];
    end
  endfunction

endpackage

// File: rtl/neuron_mac_unit_if.sv
// Activation stream, weight-memory read port and result port of one neuron.
interface neuron_mac_unit_if #(
  parameter int dataWidth    = fnn_pkg::DATA_W,
  parameter int addressWidth = 5
);

  logic                           in_valid;
  logic                           in_ready;
  logic signed [dataWidth-1:0]    in_data;
  logic                           w_ren;
  logic        [addressWidth-1:0] w_radd;
  logic signed [dataWidth-1:0]    w_data;
  logic                           out_valid;
  logic signed [dataWidth-1:0]    out_data;

  // Environment side: activation source, weight ROM and result sink.
  modport master (
    output in_valid, in_data, w_data,
    input  in_ready, w_ren, w_radd, out_valid, out_data
  );

  // Neuron side.
  modport slave (
    input  in_valid, in_data, w_data,
    output in_ready, w_ren, w_radd, out_valid, out_data
  );

endinterface

// File: rtl/fxp_mult_reg.sv
// Registered signed multiplier with a valid tag; the product is held between tokens.
module fxp_mult_reg #(
  parameter int W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic signed [W-1:0]   a,
  input  logic signed [W-1:0]   b,
  output logic                  out_valid,
  output logic signed [2*W-1:0] prod
);

  logic signed [2*W-1:0] prod_d, prod_q;
  logic                  valid_d, valid_q;
  logic signed [2*W-1:0] a_ext_s, b_ext_s;

  // Full-precision product of the current token, otherwise hold.
  always_comb begin
    a_ext_s = $signed({{W{a[W-1]}}, a});
    b_ext_s = $signed({{W{b[W-1]}}, b});
    valid_d = in_valid;
    if (in_valid) begin
      prod_d = a_ext_s * b_ext_s;
    end else begin
      prod_d = prod_q;
    end
  end

  // Product and valid registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      prod_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      prod_q  <= prod_d;
      valid_q <= valid_d;
    end
  end

  assign prod      = prod_q;
  assign out_valid = valid_q;

endmodule

// File: rtl/neuron_mac_unit.sv
// One neuron: streams activations, fetches weights, accumulates, adds bias, saturates.
module neuron_mac_unit
  import fnn_pkg::*;
#(
  parameter int numWeight    = 30,
  parameter int addressWidth = $clog2(numWeight),
  parameter int dataWidth    = DATA_W,
  parameter int fracBits     = FRAC_BITS,
  parameter int accWidth     = 2*dataWidth + $clog2(numWeight) + 1
) (
  input  logic                        clk,
  input  logic                        rst,
  neuron_mac_unit_if.slave            bus,
  input  logic signed [dataWidth-1:0] bias,
  output logic                        busy
);

  // cnt must be able to reach numWeight itself.
  localparam int              CNT_W    = $clog2(numWeight + 1);
  localparam logic [CNT_W-1:0] CNT_NUM  = CNT_W'(numWeight);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(numWeight - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  mac_state_e                  state_d, state_q;
  logic [CNT_W-1:0]            cnt_d, cnt_q;
  logic signed [dataWidth-1:0] x_d, x_q;
  logic                        v1_d, v1_q;
  logic signed [accWidth-1:0]  acc_d, acc_q;
  logic [addressWidth-1:0]     w_radd_d, w_radd_q;
  logic                        out_valid_d, out_valid_q;
  logic signed [dataWidth-1:0] out_data_d, out_data_q;
  logic                        busy_d, busy_q;

  logic                        in_ready_s;
  logic                        accept_s;
  logic                        w_ren_s;
  logic [addressWidth-1:0]     w_radd_s;
  logic                        v2_s;
  logic signed [2*dataWidth-1:0] prod_s;
  logic signed [accWidth-1:0]  prod_ext_s;
  logic signed [accWidth-1:0]  bias_ext_s;
  logic signed [accWidth-1:0]  sum_s;
  logic signed [WIDE_W-1:0]    sum_wide_s;

  // Weight fetched for x_q arrives on w_data one cycle after the accept, aligned with v1.
  fxp_mult_reg #(.W(dataWidth)) u_mult (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (v1_q),
    .a         (x_q),
    .b         (bus.w_data),
    .out_valid (v2_s),
    .prod      (prod_s)
  );

  // State register plus datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_COLLECT;
      cnt_q       <= '0;
      x_q         <= '0;
      v1_q        <= 1'b0;
      acc_q       <= '0;
      w_radd_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      x_q         <= x_d;
      v1_q        <= v1_d;
      acc_q       <= acc_d;
      w_radd_q    <= w_radd_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      busy_q      <= busy_d;
    end
  end

  // Next state: leave DRAIN once the last product is in flight to the accumulator.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_COLLECT: begin
        if (accept_s && (cnt_q == CNT_LAST)) begin
          state_d = ST_DRAIN;
        end else begin
          state_d = ST_COLLECT;
        end
      end
      ST_DRAIN: begin
        if (!v1_q) begin
          state_d = ST_EMIT;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_EMIT: begin
        state_d = ST_COLLECT;
      end
      default: begin
        state_d = ST_COLLECT;
      end
    endcase
  end

  // FSM outputs: ready, accept and the combinational weight read request.
  always_comb begin
    in_ready_s = 1'b0;
    if (rst) begin
      in_ready_s = 1'b0;
    end else if ((state_q == ST_COLLECT) && (cnt_q < CNT_NUM)) begin
      in_ready_s = 1'b1;
    end else begin
      in_ready_s = 1'b0;
    end
    accept_s = bus.in_valid && in_ready_s;
    w_ren_s  = accept_s;
    if (accept_s) begin
      w_radd_s = cnt_q[addressWidth-1:0];
    end else begin
      w_radd_s = w_radd_q;
    end
  end

  // Datapath: capture activation, accumulate products, narrow the biased sum on EMIT.
  always_comb begin
    prod_ext_s = $signed({{(accWidth-2*dataWidth){prod_s[2*dataWidth-1]}}, prod_s});
    bias_ext_s = $signed({{(accWidth-dataWidth){bias[dataWidth-1]}}, bias}) <<< fracBits;
    sum_s      = acc_q + bias_ext_s;
    sum_wide_s = $signed({{(WIDE_W-accWidth){sum_s[accWidth-1]}}, sum_s});
    v1_d       = accept_s;
    w_radd_d   = w_radd_s;

    if (accept_s) begin
      x_d = bus.in_data;
    end else begin
      x_d = x_q;
    end

    if (accept_s) begin
      cnt_d = cnt_q + CNT_ONE;
    end else if (state_q == ST_EMIT) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q;
    end

    if (state_q == ST_EMIT) begin
      acc_d = '0;
    end else if (v2_s) begin
      acc_d = acc_q + prod_ext_s;
    end else begin
      acc_d = acc_q;
    end

    if (state_q == ST_EMIT) begin
      out_valid_d = 1'b1;
      out_data_d  = sat_narrow(sum_wide_s, fracBits);
    end else begin
      out_valid_d = 1'b0;
      out_data_d  = out_data_q;
    end

    if (state_q == ST_EMIT) begin
      busy_d = 1'b0;
    end else if (accept_s) begin
      busy_d = 1'b1;
    end else begin
      busy_d = busy_q;
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.w_ren     = w_ren_s;
  assign bus.w_radd    = w_radd_s;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_neuron_mac_unit.sv
// Directed bench for neuron_mac_unit with numWeight=4 and a 1-cycle-latency weight ROM model.
module tb_neuron_mac_unit;

  localparam int NW = 4;
  localparam int DW = 16;
  localparam int AW = 2;

  logic                 clk;
  logic                 rst;
  logic signed [DW-1:0] bias;
  logic                 busy;

  int errors;
  int checks;

  logic [DW-1:0] x_vec [NW];
  logic [DW-1:0] wmem  [NW];

  neuron_mac_unit_if #(.dataWidth(DW), .addressWidth(AW)) bus ();

  neuron_mac_unit #(
    .numWeight    (NW),
    .addressWidth (AW),
    .dataWidth    (DW),
    .fracBits     (12)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .bias (bias),
    .busy (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Weight ROM model: registered read, one cycle latency.
  always @(posedge clk) begin
    if (bus.w_ren === 1'b1) begin
      bus.w_data <= wmem[bus.w_radd];
    end
  end

  task automatic load(input logic [DW-1:0] x0, input logic [DW-1:0] x1,
                      input logic [DW-1:0] x2, input logic [DW-1:0] x3,
                      input logic [DW-1:0] w, input logic [DW-1:0] b);
    x_vec[0] = x0; x_vec[1] = x1; x_vec[2] = x2; x_vec[3] = x3;
    for (int i = 0; i < NW; i++) wmem[i] = w;
    bias = b;
  endtask

  // Offer x_vec[first..last] with 'gap' idle cycles between samples; count bad handshake/address samples.
  task automatic feed_vec(input int gap, input int first, input int last, output int bad);
    logic [AW-1:0] exp_addr;
    bad = 0;
    for (int i = first; i <= last; i++) begin
      exp_addr = AW'(i);
      bus.in_valid = 1'b1;
      bus.in_data  = x_vec[i];
      #1;
      if (bus.in_ready !== 1'b1 || bus.w_ren !== 1'b1 || bus.w_radd !== exp_addr) bad++;
      @(negedge clk);
      bus.in_valid = 1'b0;
      if (i < last) begin
        for (int g = 0; g < gap; g++) begin
          #1;
          if (bus.w_ren !== 1'b0 || bus.w_radd !== exp_addr) bad++;
          @(negedge clk);
        end
      end
    end
    bus.in_valid = 1'b0;
  endtask

  // Entered in cycle N+1 after the last accept; lat is the cycle offset where out_valid shows.
  task automatic wait_out(output int lat, output logic [DW-1:0] data, output int bad);
    lat = 1;
    bad = 0;
    #1;
    while (bus.out_valid !== 1'b1 && lat < 12) begin
      if (bus.in_ready !== 1'b0 || busy !== 1'b1) bad++;
      @(negedge clk);
      #1;
      lat++;
    end
    data = bus.out_data;
    if (bus.in_ready !== 1'b1 || busy !== 1'b0) bad++;
    @(negedge clk);
    #1;
    if (bus.out_valid !== 1'b0 || bus.out_data !== data) bad++;
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bias = '0;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b expected 0", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
    checks++; if (bus.out_data !== 16'h0000) begin errors++; $display("FAIL reset_out_data: got %h expected 0000", bus.out_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (bus.w_ren !== 1'b0 || bus.w_radd !== 2'd0) begin errors++; $display("FAIL reset_wport: got ren=%b radd=%0d expected 0/0", bus.w_ren, bus.w_radd); end
    rst = 1'b0;
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready: got %b expected 1", bus.in_ready); end
    @(negedge clk);
  endtask

  task automatic test_basic;
    int bad; int lat; int dbad; logic [DW-1:0] data;
    load(16'h1000, 16'h2000, 16'h0800, 16'h0000, 16'h1000, 16'h0000);
    feed_vec(0, 0, 3, bad);
    checks++; if (bad !== 0) begin errors++; $display("FAIL basic_addr: got %0d bad samples expected 0", bad); end
    wait_out(lat, data, dbad);
    checks++; if (lat !== 4) begin errors++; $display("FAIL basic_latency: got %0d expected 4", lat); end
    checks++; if (data !== 16'h3800) begin errors++; $display("FAIL basic_data: got %h expected 3800", data); end
    checks++; if (dbad !== 0) begin errors++; $display("FAIL basic_drain: got %0d bad samples expected 0", dbad); end
  endtask

  task automatic test_saturation;
    int bad; int lat; int dbad; logic [DW-1:0] data;
    load(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
    feed_vec(0, 0, 3, bad);
    wait_out(lat, data, dbad);
    checks++; if (data !== 16'h7FFF) begin errors++; $display("FAIL sat_pos: got %h expected 7fff", data); end
    load(16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h7FFF, 16'h0000);
    feed_vec(0, 0, 3, bad);
    wait_out(lat, data, dbad);
    checks++; if (data !== 16'h8000) begin errors++; $display("FAIL sat_neg: got %h expected 8000", data); end
    checks++; if (lat !== 4 || bad !== 0 || dbad !== 0) begin errors++; $display("FAIL sat_neg_timing: got lat=%0d bad=%0d dbad=%0d expected 4/0/0", lat, bad, dbad); end
  endtask

  task automatic test_bias;
    int bad; int lat; int dbad; logic [DW-1:0] data;
    load(16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h1000, 16'h0400);
    feed_vec(0, 0, 3, bad);
    wait_out(lat, data, dbad);
    checks++; if (data !== 16'h0400) begin errors++; $display("FAIL bias_pos: got %h expected 0400", data); end
    load(16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h1000, 16'hFC00);
    feed_vec(0, 0, 3, bad);
    wait_out(lat, data, dbad);
    checks++; if (data !== 16'hFC00) begin errors++; $display("FAIL bias_neg: got %h expected fc00", data); end
  endtask

  task automatic test_rounding;
    int bad; int lat; int dbad; logic [DW-1:0] data;
    // -1 LSB * 0.5 = -2048 raw -> shifting right by 12 floors to -1.
    load(16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 16'h0800, 16'h0000);
    feed_vec(0, 0, 3, bad);
    wait_out(lat, data, dbad);
    checks++; if (data !== 16'hFFFF) begin errors++; $display("FAIL round_floor: got %h expected ffff", data); end
  endtask

  task automatic test_gaps;
    int bad; int lat; int dbad; logic [DW-1:0] data;
    load(16'h1000, 16'h2000, 16'h0800, 16'h0000, 16'h1000, 16'h0000);
    feed_vec(3, 0, 3, bad);
    checks++; if (bad !== 0) begin errors++; $display("FAIL gaps_wport: got %0d bad samples expected 0", bad); end
    wait_out(lat, data, dbad);
    checks++; if (data !== 16'h3800) begin errors++; $display("FAIL gaps_data: got %h expected 3800", data); end
    checks++; if (lat !== 4 || dbad !== 0) begin errors++; $display("FAIL gaps_timing: got lat=%0d dbad=%0d expected 4/0", lat, dbad); end
  endtask

  task automatic test_back_to_back;
    int bad; int lat; int dbad; int nready; int ren_bad; logic [DW-1:0] data;
    load(16'h1000, 16'h2000, 16'h0800, 16'h0000, 16'h1000, 16'h0000);
    feed_vec(0, 0, 3, bad);
    // Second vector (4 x 1.0) offered immediately and held through the drain.
    load(16'h1000, 16'h1000, 16'h1000, 16'h1000, 16'h1000, 16'h0000);
    bus.in_valid = 1'b1;
    bus.in_data  = x_vec[0];
    lat = 1; nready = 0; ren_bad = 0;
    #1;
    while (bus.out_valid !== 1'b1 && lat < 12) begin
      if (bus.in_ready === 1'b0) nready++;
      if (bus.w_ren !== 1'b0) ren_bad++;
      @(negedge clk);
      #1;
      lat++;
    end
    checks++; if (lat !== 4) begin errors++; $display("FAIL b2b_latency: got %0d expected 4", lat); end
    checks++; if (nready !== 3) begin errors++; $display("FAIL b2b_stall_cycles: got %0d expected 3", nready); end
    checks++; if (ren_bad !== 0) begin errors++; $display("FAIL b2b_ren_in_drain: got %0d expected 0", ren_bad); end
    checks++; if (bus.out_data !== 16'h3800) begin errors++; $display("FAIL b2b_first_data: got %h expected 3800", bus.out_data); end
    checks++; if (bus.in_ready !== 1'b1 || bus.w_ren !== 1'b1 || bus.w_radd !== 2'd0) begin errors++; $display("FAIL b2b_restart: got rdy=%b ren=%b radd=%0d expected 1/1/0", bus.in_ready, bus.w_ren, bus.w_radd); end
    @(negedge clk);
    feed_vec(0, 1, 3, bad);
    checks++; if (bad !== 0) begin errors++; $display("FAIL b2b_second_addr: got %0d bad samples expected 0", bad); end
    wait_out(lat, data, dbad);
    checks++; if (data !== 16'h4000) begin errors++; $display("FAIL b2b_second_data: got %h expected 4000", data); end
  endtask

  task automatic test_reset_mid;
    int bad; int lat; int dbad; int seen; logic [DW-1:0] data;
    load(16'h1000, 16'h2000, 16'h0800, 16'h0000, 16'h1000, 16'h0000);
    feed_vec(0, 0, 1, bad);
    rst = 1'b1;
    @(negedge clk);
    #1;
    checks++; if (bus.in_ready !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL midrst_state: got rdy=%b busy=%b expected 0/0", bus.in_ready, busy); end
    rst = 1'b0;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      #1;
      if (bus.out_valid !== 1'b0) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL midrst_no_output: got %0d out_valid cycles expected 0", seen); end
    @(negedge clk);
    feed_vec(0, 0, 3, bad);
    checks++; if (bad !== 0) begin errors++; $display("FAIL midrst_addr: got %0d bad samples expected 0", bad); end
    wait_out(lat, data, dbad);
    checks++; if (data !== 16'h3800 || lat !== 4) begin errors++; $display("FAIL midrst_data: got %h lat=%0d expected 3800 lat=4", data, lat); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    for (int i = 0; i < NW; i++) begin
      x_vec[i] = '0;
      wmem[i]  = '0;
    end
    test_reset();
    test_basic();
    test_saturation();
    test_bias();
    test_rounding();
    test_gaps();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
